// File: rtl/gaussian_pkg.sv
// ----------------------------------------------------------------------------
// gaussian_pkg
//   Shared constants and types for the 5x5 Gaussian convolution engine:
//   kernel size, coefficient fixed-point format, default datapath widths and
//   the engine's state encoding.
//   Optional build macro used by this block: GAUSS_ROUND_EN (see
//   gaussian_round_sat).
// ----------------------------------------------------------------------------
package gaussian_pkg;

    // Kernel geometry: 25 taps in raster order, tap index fits in 5 bits.
    localparam int TAPS      = 25;
    localparam int K_W       = 5;

    // Coefficients are unsigned Q4.12.
    localparam int COEF_FRAC = 12;

    // Default datapath widths.
    localparam int PIX_W_DEF  = 8;
    localparam int COEF_W_DEF = 16;
    localparam int ACC_W_DEF  = 24;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // waiting for the first tap of a window
        ST_ACCUM = 2'd1,   // collecting taps 1..24
        ST_OUT   = 2'd2    // holding the filtered pixel until it is taken
    } state_e;

endpackage : gaussian_pkg

// File: rtl/gaussian_round_sat.sv
// ----------------------------------------------------------------------------
// gaussian_round_sat
//   Combinational normaliser: turns the Q4.12-weighted accumulator into an
//   output pixel.  res = (acc + RND) >> COEF_FRAC, saturated to the pixel
//   maximum.
//   Build option: GAUSS_ROUND_EN defined -> RND = 1 << (COEF_FRAC-1)
//   (round half up); undefined -> RND = 0 (truncate).
//
// Ports
//   acc_i    in   ACC_W  accumulated sum of pixel*coefficient products
//   pixel_o  out  PIX_W  normalised, saturated pixel
// ----------------------------------------------------------------------------
module gaussian_round_sat
    import gaussian_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int PIX_W = PIX_W_DEF
) (
    input  logic [ACC_W-1:0] acc_i,
    output logic [PIX_W-1:0] pixel_o
);

`ifdef GAUSS_ROUND_EN
    localparam logic [ACC_W:0] RND = (ACC_W+1)'(1) << (COEF_FRAC - 1);
`else
    localparam logic [ACC_W:0] RND = '0;
`endif

    localparam logic [ACC_W:0] PIX_MAX = (ACC_W+1)'((1 << PIX_W) - 1);

    logic [ACC_W:0] sum;
    logic [ACC_W:0] res;

    // One extra bit so the rounding constant can never wrap the sum.
    assign sum     = {1'b0, acc_i} + RND;
    assign res     = sum >> COEF_FRAC;
    assign pixel_o = (res > PIX_MAX) ? '1 : res[PIX_W-1:0];

endmodule : gaussian_round_sat

// File: rtl/gaussian_mac.sv
// ----------------------------------------------------------------------------
// gaussian_mac
//   Streaming 5x5 Gaussian convolution engine.  Takes the 25 pixels of a
//   window in raster order, looks up each tap's Q4.12 coefficient in an
//   external combinational ROM (rom_addr -> rom_data, same cycle), multiply-
//   accumulates, and after the 25th tap presents one normalised 8-bit pixel
//   on a valid/ready output.
//   Build option: GAUSS_ROUND_EN selects round-half-up instead of truncation
//   in the normaliser.
//
// Ports
//   clk        in   1       rising-edge clock
//   rst        in   1       asynchronous reset, active-high
//   clear      in   1       synchronous abort of the current window
//   in_valid   in   1       in_pixel valid
//   in_ready   out  1       a tap can be accepted this cycle
//   in_pixel   in   PIX_W   window pixel k
//   rom_addr   out  5       coefficient index (= tap counter k)
//   rom_data   in   COEF_W  coefficient for rom_addr
//   out_valid  out  1       out_pixel valid
//   out_ready  in   1       downstream accepts out_pixel
//   out_pixel  out  PIX_W   filtered pixel
//   busy       out  1       engine is not idle
// ----------------------------------------------------------------------------
module gaussian_mac
    import gaussian_pkg::*;
#(
    parameter int PIX_W  = PIX_W_DEF,
    parameter int COEF_W = COEF_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PIX_W-1:0]  in_pixel,
    output logic [K_W-1:0]    rom_addr,
    input  logic [COEF_W-1:0] rom_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PIX_W-1:0]  out_pixel,
    output logic              busy
);

    localparam int            PROD_W = PIX_W + COEF_W;
    localparam logic [K_W-1:0] LAST_K = K_W'(TAPS - 1);

    state_e             state_q, state_d;
    logic [K_W-1:0]     k_q, k_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               out_valid_q, out_valid_d;
    logic [PIX_W-1:0]   out_pixel_q, out_pixel_d;
    // Low only during and directly after reset, so in_ready stays 0 for the
    // reset cycle.
    logic               ready_en_q;

    logic               tap;
    logic [PROD_W-1:0]  product;
    logic [ACC_W-1:0]   acc_sum;
    logic [PIX_W-1:0]   norm_pixel;

    assign in_ready  = ready_en_q && (state_q != ST_OUT);
    assign tap       = in_valid && in_ready;
    assign rom_addr  = k_q;
    assign out_valid = out_valid_q;
    assign out_pixel = out_pixel_q;
    assign busy      = (state_q != ST_IDLE);

    assign product = PROD_W'(in_pixel) * PROD_W'(rom_data);
    assign acc_sum = acc_q + ACC_W'(product);

    // Normalise the sum that includes the final tap so the result can be
    // registered on the same edge that accepts tap 24.
    gaussian_round_sat #(
        .ACC_W (ACC_W),
        .PIX_W (PIX_W)
    ) u_round_sat (
        .acc_i   (acc_sum),
        .pixel_o (norm_pixel)
    );

    always_comb begin
        // NOTE: every signal driven here gets a default first; otherwise any
        // path that skips an assignment infers a latch.
        state_d     = state_q;
        k_d         = k_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_pixel_d = out_pixel_q;

        if (clear) begin
            // Abort wins over a coincident tap or output handshake.
            state_d     = ST_IDLE;
            k_d         = '0;
            acc_d       = '0;
            out_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (tap) begin
                        // First tap loads rather than accumulates.
                        acc_d   = ACC_W'(product);
                        k_d     = k_q + K_W'(1);
                        state_d = ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (tap) begin
                        acc_d = acc_sum;
                        if (k_q == LAST_K) begin
                            k_d         = '0;
                            out_pixel_d = norm_pixel;
                            out_valid_d = 1'b1;
                            state_d     = ST_OUT;
                        end else begin
                            k_d = k_q + K_W'(1);
                        end
                    end
                end
                ST_OUT: begin
                    if (out_valid_q && out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_pixel_q <= '0;
            ready_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_pixel_q <= out_pixel_d;
            ready_en_q  <= 1'b1;
        end
    end

endmodule : gaussian_mac

// File: tb/tb_gaussian_mac.sv
// ----------------------------------------------------------------------------
// tb_gaussian_mac
//   Self-checking bench for gaussian_mac with a local model of the
//   coefficient ROM.  Expected pixels go into a scoreboard queue when a
//   window's last tap is driven and are compared when the output handshake
//   happens.  Honours GAUSS_ROUND_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_gaussian_mac;

    localparam int TAPS = 25;

`ifdef GAUSS_ROUND_EN
    localparam int RND = 2048;
`else
    localparam int RND = 0;
`endif

    typedef logic [7:0] win_t [TAPS];

    typedef struct {
        int kind;      // 0: flat window of val, 1: val at pos, 0 elsewhere
        int val;
        int pos;
        int exp_rnd;   // expected pixel with rounding
        int exp_trn;   // expected pixel with truncation
    } vec_t;

    // Symmetric kernel, sum 4098, centre 386.
    logic [15:0] coef_rom [TAPS] = '{
        16'd38,  16'd100, 16'd150, 16'd100, 16'd38,
        16'd100, 16'd240, 16'd300, 16'd240, 16'd100,
        16'd150, 16'd300, 16'd386, 16'd300, 16'd150,
        16'd100, 16'd240, 16'd300, 16'd240, 16'd100,
        16'd38,  16'd100, 16'd150, 16'd100, 16'd38
    };

    logic        clk;
    logic        rst;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_pixel;
    logic [4:0]  rom_addr;
    logic [15:0] rom_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_pixel;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    gaussian_mac dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pixel  (in_pixel),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pixel (out_pixel),
        .busy      (busy)
    );

    assign rom_data = (int'(rom_addr) < TAPS) ? coef_rom[int'(rom_addr)] : 16'd0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model(input win_t w);
        int acc = 0;
        int res;
        for (int i = 0; i < TAPS; i++) acc += int'(w[i]) * int'(coef_rom[i]);
        res = (acc + RND) >>> 12;
        return (res > 255) ? 255 : res;
    endfunction

    // Scoreboard consumer: sampled 1 time unit after the falling edge so
    // inputs changed at that edge have settled; handshake happens at the
    // following rising edge.
    always @(negedge clk) begin
        #1;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                check("out_pixel", int'(out_pixel), exp_q.pop_front());
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send_tap(input logic [7:0] p);
        int n = 0;
        in_valid = 1'b1;
        in_pixel = p;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("in_ready_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_window(input win_t w, input int exp, input int gap_max);
        for (int i = 0; i < TAPS; i++) begin
            int gap = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
            for (int g = 0; g < gap; g++) @(negedge clk);
            if (i == TAPS - 1) exp_q.push_back(exp);
            send_tap(w[i]);
        end
    endtask

    function automatic win_t flat(input int v);
        win_t w;
        for (int i = 0; i < TAPS; i++) w[i] = 8'(v);
        return w;
    endfunction

    function automatic win_t impulse(input int v, input int pos);
        win_t w;
        for (int i = 0; i < TAPS; i++) w[i] = (i == pos) ? 8'(v) : 8'd0;
        return w;
    endfunction

    initial begin
        vec_t vecs[8];
        win_t w;
        int   held;
        int   n;

        vecs[0] = '{kind: 0, val: 100, pos: 0,  exp_rnd: 100, exp_trn: 100};
        vecs[1] = '{kind: 0, val: 255, pos: 0,  exp_rnd: 255, exp_trn: 255};
        vecs[2] = '{kind: 1, val: 200, pos: 12, exp_rnd: 19,  exp_trn: 18};
        vecs[3] = '{kind: 0, val: 0,   pos: 0,  exp_rnd: 0,   exp_trn: 0};
        vecs[4] = '{kind: 1, val: 255, pos: 7,  exp_rnd: 19,  exp_trn: 18};
        vecs[5] = '{kind: 1, val: 255, pos: 0,  exp_rnd: 2,   exp_trn: 2};
        vecs[6] = '{kind: 1, val: 150, pos: 12, exp_rnd: 14,  exp_trn: 14};
        vecs[7] = '{kind: 0, val: 50,  pos: 0,  exp_rnd: 50,  exp_trn: 50};

        rst       = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_pixel  = 8'd0;
        out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_rom_addr", int'(rom_addr), 0);
        check("rst_out_pixel", int'(out_pixel), 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", int'(in_ready), 1);

        // Test 1: flat 100, output exactly one cycle after the last tap
        w = flat(100);
        for (int i = 0; i < TAPS - 1; i++) send_tap(w[i]);
        check("k_before_last", int'(rom_addr), 24);
        check("busy_accum", int'(busy), 1);
        check("out_valid_early", int'(out_valid), 0);
        exp_q.push_back(100);
        send_tap(w[TAPS-1]);
        check("out_valid_latency", int'(out_valid), 1);
        check("in_ready_in_out", int'(in_ready), 0);
        check("k_wrapped", int'(rom_addr), 0);
        @(negedge clk);
        check("out_valid_dropped", int'(out_valid), 0);
        check("in_ready_after_hs", int'(in_ready), 1);

        // Table-driven windows
        foreach (vecs[i]) begin
            w = (vecs[i].kind == 0) ? flat(vecs[i].val) : impulse(vecs[i].val, vecs[i].pos);
`ifdef GAUSS_ROUND_EN
            send_window(w, vecs[i].exp_rnd, 0);
`else
            send_window(w, vecs[i].exp_trn, 0);
`endif
            check("table_model", model(w),
`ifdef GAUSS_ROUND_EN
                  vecs[i].exp_rnd);
`else
                  vecs[i].exp_trn);
`endif
        end

        // Test 4: output back-pressure
        @(negedge clk);
        out_ready = 1'b0;
        send_window(impulse(200, 12), (RND != 0) ? 19 : 18, 0);
        held = int'(out_pixel);
        check("bp_pixel_value", held, (RND != 0) ? 19 : 18);
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            in_pixel = 8'd77;
            @(negedge clk);
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_out_pixel", int'(out_pixel), held);
            check("bp_in_ready", int'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        send_window(flat(100), 100, 0);

        // Test 5: clear at k=10 with a coincident tap
        @(negedge clk);
        for (int i = 0; i < 10; i++) send_tap(8'd200);
        check("k_before_clear", int'(rom_addr), 10);
        in_valid = 1'b1;
        in_pixel = 8'd50;
        clear    = 1'b1;
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clear_k", int'(rom_addr), 0);
        check("clear_busy", int'(busy), 0);
        send_window(flat(100), 100, 0);

        // Test 6: asynchronous reset mid-window
        @(negedge clk);
        for (int i = 0; i < 7; i++) send_tap(8'd123);
        check("k_before_rst", int'(rom_addr), 7);
        in_valid = 1'b1;
        in_pixel = 8'd9;
        #2 rst = 1'b1;
        #1;
        check("arst_busy", int'(busy), 0);
        check("arst_rom_addr", int'(rom_addr), 0);
        check("arst_in_ready", int'(in_ready), 0);
        check("arst_out_valid", int'(out_valid), 0);
        check("arst_out_pixel", int'(out_pixel), 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b0;
        @(negedge clk);
        for (int i = 0; i < TAPS; i++) w[i] = 8'($urandom_range(255, 0));
        send_window(w, model(w), 0);
        @(negedge clk);
        send_window(w, model(w), 4);

        // Drain the scoreboard
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_gaussian_mac
